// File: rtl/deconvolve_multi_pkg.sv
// Shared defaults and types for the time-multiplexed FADC deconvolver.
// Widths follow the compatibility ToT-deconvolved trigger path.
package deconvolve_multi_pkg;

    localparam int DEF_NCH          = 3;
    localparam int DEF_ADC_WIDTH    = 12;
    localparam int DEF_FD_BITS      = 6;
    localparam int DEF_FN_BITS      = 6;
    localparam int DEF_FN_FRAC_BITS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deconvolve_multi_pipe.sv
// Single-channel-wide deconvolution datapath: x*2^FD - p*FD, clamp, *FN, round, saturate.
// Eight register stages from issue to the saturated result presented at the outputs.
module deconvolve_multi_pipe
    import deconvolve_multi_pkg::*;
#(
    parameter int ADC_WIDTH    = DEF_ADC_WIDTH,
    parameter int FD_BITS      = DEF_FD_BITS,
    parameter int FN_BITS      = DEF_FN_BITS,
    parameter int FN_FRAC_BITS = DEF_FN_FRAC_BITS,
    parameter int CH_W         = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_vld,
    input  logic [CH_W-1:0]      i_ch,
    input  logic                 i_byp,
    input  logic [ADC_WIDTH-1:0] i_x,
    input  logic [ADC_WIDTH-1:0] i_p,
    input  logic [FD_BITS-1:0]   i_fd,
    input  logic [FN_BITS-1:0]   i_fn,
    output logic                 o_vld,
    output logic [CH_W-1:0]      o_ch,
    output logic                 o_sat,
    output logic [ADC_WIDTH-1:0] o_res
);

    localparam int PW = ADC_WIDTH + FD_BITS;
    localparam int BW = PW + 1;
    localparam int DW = PW + FN_BITS;
    localparam int EW = DW + 1;
    localparam int SH = FD_BITS + FN_FRAC_BITS;
    localparam int TW = CH_W + 1 + ADC_WIDTH;

    function automatic logic [PW-1:0] clamp_pos(input logic signed [BW-1:0] b);
        return b[BW-1] ? '0 : b[PW-1:0];
    endfunction

    function automatic logic [EW-1:0] round_half_up(input logic [DW-1:0] d);
        logic [EW-1:0] half;
        half = EW'(1) << (SH - 1);
        return EW'(d) + half;
    endfunction

    // Returns {saturated, value}
    function automatic logic [ADC_WIDTH:0] saturate(input logic [EW-1:0] e);
        logic [EW-1:0] s;
        s = e >> SH;
        if ((s >> ADC_WIDTH) != '0)
            return {1'b1, {ADC_WIDTH{1'b1}}};
        return {1'b0, s[ADC_WIDTH-1:0]};
    endfunction

    logic                 r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic                 r_vld_p4, r_vld_p5, r_vld_p6, r_vld_p7;
    logic [TW-1:0]        r_tag_p0, r_tag_p1, r_tag_p2, r_tag_p3;
    logic [TW-1:0]        r_tag_p4, r_tag_p5, r_tag_p6, r_tag_p7;
    logic [ADC_WIDTH-1:0] r_p_p0;
    logic [FD_BITS-1:0]   r_fd_p0;
    logic [FN_BITS-1:0]   r_fn_p0, r_fn_p1, r_fn_p2, r_fn_p3, r_fn_p4;
    logic [PW-1:0]        r_prod_p1, r_prod_p2;
    logic signed [BW-1:0] r_b_p3;
    logic [PW-1:0]        r_c_p4;
    logic [DW-1:0]        r_d_p5, r_d_p6;
    logic [EW-1:0]        r_e_p7;
    logic [ADC_WIDTH:0]   w_sat_res;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_p0 <= 1'b0; r_vld_p1 <= 1'b0; r_vld_p2 <= 1'b0; r_vld_p3 <= 1'b0;
            r_vld_p4 <= 1'b0; r_vld_p5 <= 1'b0; r_vld_p6 <= 1'b0; r_vld_p7 <= 1'b0;
            r_tag_p0 <= '0; r_tag_p1 <= '0; r_tag_p2 <= '0; r_tag_p3 <= '0;
            r_tag_p4 <= '0; r_tag_p5 <= '0; r_tag_p6 <= '0; r_tag_p7 <= '0;
            r_p_p0   <= '0;
            r_fd_p0  <= '0;
            r_fn_p0  <= '0; r_fn_p1 <= '0; r_fn_p2 <= '0; r_fn_p3 <= '0; r_fn_p4 <= '0;
            r_prod_p1 <= '0;
            r_prod_p2 <= '0;
            r_b_p3   <= '0;
            r_c_p4   <= '0;
            r_d_p5   <= '0;
            r_d_p6   <= '0;
            r_e_p7   <= '0;
        end else begin
            // p0: issue
            r_vld_p0 <= i_vld;
            r_tag_p0 <= {i_ch, i_byp, i_x};
            r_p_p0   <= i_p;
            r_fd_p0  <= i_fd;
            r_fn_p0  <= i_fn;
            // p1/p2: decay product, registered twice for the DSP M/P registers
            r_vld_p1  <= r_vld_p0;
            r_tag_p1  <= r_tag_p0;
            r_fn_p1   <= r_fn_p0;
            r_prod_p1 <= PW'(r_p_p0) * PW'(r_fd_p0);
            r_vld_p2  <= r_vld_p1;
            r_tag_p2  <= r_tag_p1;
            r_fn_p2   <= r_fn_p1;
            r_prod_p2 <= r_prod_p1;
            // p3: subtract
            r_vld_p3 <= r_vld_p2;
            r_tag_p3 <= r_tag_p2;
            r_fn_p3  <= r_fn_p2;
            r_b_p3   <= $signed({1'b0, r_tag_p2[ADC_WIDTH-1:0], {FD_BITS{1'b0}}})
                      - $signed({1'b0, r_prod_p2});
            // p4: clamp
            r_vld_p4 <= r_vld_p3;
            r_tag_p4 <= r_tag_p3;
            r_fn_p4  <= r_fn_p3;
            r_c_p4   <= clamp_pos(r_b_p3);
            // p5/p6: normalise product, registered twice
            r_vld_p5 <= r_vld_p4;
            r_tag_p5 <= r_tag_p4;
            r_d_p5   <= DW'(r_c_p4) * DW'(r_fn_p4);
            r_vld_p6 <= r_vld_p5;
            r_tag_p6 <= r_tag_p5;
            r_d_p6   <= r_d_p5;
            // p7: round
            r_vld_p7 <= r_vld_p6;
            r_tag_p7 <= r_tag_p6;
            r_e_p7   <= round_half_up(r_d_p6);
        end
    end

    assign w_sat_res = saturate(r_e_p7);
    assign o_vld     = r_vld_p7;
    assign o_ch      = r_tag_p7[TW-1 -: CH_W];
    assign o_res     = r_tag_p7[ADC_WIDTH] ? r_tag_p7[ADC_WIDTH-1:0] : w_sat_res[ADC_WIDTH-1:0];
    assign o_sat     = ~r_tag_p7[ADC_WIDTH] & w_sat_res[ADC_WIDTH];

endmodule

// File: rtl/deconvolve_multi.sv
// NCH-channel FADC deconvolver sharing one pipeline: sequences channels from a hold
// register, keeps per-channel previous samples, demuxes results and tracks sticky flags.
module deconvolve_multi
    import deconvolve_multi_pkg::*;
#(
    parameter int NCH          = DEF_NCH,
    parameter int ADC_WIDTH    = DEF_ADC_WIDTH,
    parameter int FD_BITS      = DEF_FD_BITS,
    parameter int FN_BITS      = DEF_FN_BITS,
    parameter int FN_FRAC_BITS = DEF_FN_FRAC_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    input  logic [NCH*ADC_WIDTH-1:0] i_adc_in,
    input  logic [NCH*FD_BITS-1:0]   i_fd,
    input  logic [NCH*FN_BITS-1:0]   i_fn,
    input  logic                     i_bypass,
    input  logic                     i_sat_clr,
    output logic [NCH*ADC_WIDTH-1:0] o_adc_out,
    output logic                     o_out_valid,
    output logic [NCH-1:0]           o_sat,
    output logic                     o_overrun
);

    localparam int              CH_W = ch_width(NCH);
    localparam logic [CH_W-1:0] LAST = CH_W'(NCH - 1);

    seq_state_e           r_state, w_state_nxt;
    logic [CH_W-1:0]      r_cnt;
    logic                 r_bypass;
    logic [ADC_WIDTH-1:0] r_hold [NCH];
    logic [ADC_WIDTH-1:0] r_prev [NCH];
    logic [ADC_WIDTH-1:0] r_out  [NCH];
    logic [NCH-1:0]       r_sat;
    logic                 r_overrun;
    logic                 r_out_valid;

    logic                 w_last, w_issue, w_accept, w_ovr_evt;
    logic [ADC_WIDTH-1:0] w_x, w_p;
    logic [FD_BITS-1:0]   w_fd;
    logic [FN_BITS-1:0]   w_fn;
    logic [NCH-1:0]       w_sat_set;
    logic                 w_pvld, w_psat;
    logic [CH_W-1:0]      w_pch;
    logic [ADC_WIDTH-1:0] w_pres;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A new strobe is taken in the same cycle the last channel of the previous set issues.
    always_comb begin
        w_state_nxt = r_state;
        if (i_in_valid && (r_state == ST_IDLE || w_last))
            w_state_nxt = ST_SEQ;
        else if (r_state == ST_SEQ && w_last)
            w_state_nxt = ST_IDLE;
    end

    always_comb begin
        w_issue   = (r_state == ST_SEQ);
        w_accept  = i_in_valid && (!w_issue || w_last);
        w_ovr_evt = i_in_valid && w_issue && !w_last;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_bypass <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_hold[k] <= '0;
                r_prev[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_bypass <= i_bypass;
                for (int k = 0; k < NCH; k++)
                    r_hold[k] <= i_adc_in[k*ADC_WIDTH +: ADC_WIDTH];
            end else if (w_issue) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_issue) begin
                for (int k = 0; k < NCH; k++)
                    if (r_cnt == CH_W'(k)) r_prev[k] <= r_hold[k];
            end
        end
    end

    always_comb begin
        w_x  = '0;
        w_p  = '0;
        w_fd = '0;
        w_fn = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CH_W'(k)) begin
                w_x  = r_hold[k];
                w_p  = r_prev[k];
                w_fd = i_fd[k*FD_BITS +: FD_BITS];
                w_fn = i_fn[k*FN_BITS +: FN_BITS];
            end
        end
    end

    deconvolve_multi_pipe #(
        .ADC_WIDTH    (ADC_WIDTH),
        .FD_BITS      (FD_BITS),
        .FN_BITS      (FN_BITS),
        .FN_FRAC_BITS (FN_FRAC_BITS),
        .CH_W         (CH_W)
    ) u_pipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_vld   (w_issue),
        .i_ch    (r_cnt),
        .i_byp   (r_bypass),
        .i_x     (w_x),
        .i_p     (w_p),
        .i_fd    (w_fd),
        .i_fn    (w_fn),
        .o_vld   (w_pvld),
        .o_ch    (w_pch),
        .o_sat   (w_psat),
        .o_res   (w_pres)
    );

    always_comb begin
        w_sat_set = '0;
        for (int k = 0; k < NCH; k++)
            if (w_pvld && w_psat && w_pch == CH_W'(k)) w_sat_set[k] = 1'b1;
    end

    // Sticky flags: a new event in the clear cycle still sets the flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_sat       <= '0;
            r_overrun   <= 1'b0;
            for (int k = 0; k < NCH; k++) r_out[k] <= '0;
        end else begin
            r_out_valid <= w_pvld && (w_pch == LAST);
            r_sat       <= (i_sat_clr ? '0 : r_sat) | w_sat_set;
            r_overrun   <= (i_sat_clr ? 1'b0 : r_overrun) | w_ovr_evt;
            for (int k = 0; k < NCH; k++)
                if (w_pvld && w_pch == CH_W'(k)) r_out[k] <= w_pres;
        end
    end

    always_comb begin
        o_adc_out = '0;
        for (int k = 0; k < NCH; k++)
            o_adc_out[k*ADC_WIDTH +: ADC_WIDTH] = r_out[k];
    end

    assign o_out_valid = r_out_valid;
    assign o_sat       = r_sat;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_deconvolve_multi.sv
// Scoreboard bench for deconvolve_multi: directed cases plus randomized sample sets
// against a real-valued reference of out = round(FN * max(0, x - FD*prev)).
module tb_deconvolve_multi;

    localparam int NCH = 3;
    localparam int A   = 12;
    localparam int F   = 6;
    localparam int N   = 6;
    localparam int FR  = 4;
    localparam int LATENCY = 8;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_in_valid = 1'b0;
    logic [NCH*A-1:0]   i_adc_in = '0;
    logic [NCH*F-1:0]   i_fd = '0;
    logic [NCH*N-1:0]   i_fn = '0;
    logic               i_bypass = 1'b0;
    logic               i_sat_clr = 1'b0;
    logic [NCH*A-1:0]   o_adc_out;
    logic               o_out_valid;
    logic [NCH-1:0]     o_sat;
    logic               o_overrun;

    always #4 clk = ~clk;

    deconvolve_multi #(
        .NCH(NCH), .ADC_WIDTH(A), .FD_BITS(F), .FN_BITS(N), .FN_FRAC_BITS(FR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .i_adc_in    (i_adc_in),
        .i_fd        (i_fd),
        .i_fn        (i_fn),
        .i_bypass    (i_bypass),
        .i_sat_clr   (i_sat_clr),
        .o_adc_out   (o_adc_out),
        .o_out_valid (o_out_valid),
        .o_sat       (o_sat),
        .o_overrun   (o_overrun)
    );

    typedef struct packed {
        logic [NCH*A-1:0] vals;
        logic [NCH-1:0]   sat;
        logic [31:0]      t0;
    } exp_t;

    exp_t           q[$];
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    int             prev[NCH];
    int             fdv[NCH];
    int             fnv[NCH];
    int             last_acc = -1000;
    bit             m_ovr = 1'b0;
    logic [NCH-1:0] m_sat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: y = max(0, x - prev*FD/2^F) * FN/2^FR, rounded half up, clipped to full scale
    function automatic void ref_chan(input int x, input int p, input int fd, input int fn,
                                     output int v, output bit s);
        real y;
        int  r;
        y = real'(x) - real'(p) * real'(fd) / (2.0 ** F);
        if (y < 0.0) y = 0.0;
        y = y * real'(fn) / (2.0 ** FR);
        r = $rtoi($floor(y + 0.5));
        if (r > (1 << A) - 1) begin
            v = (1 << A) - 1;
            s = 1'b1;
        end else begin
            v = r;
            s = 1'b0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_consts();
        for (int k = 0; k < NCH; k++) begin
            i_fd[k*F +: F] = F'(fdv[k]);
            i_fn[k*N +: N] = N'(fnv[k]);
        end
    endtask

    task automatic all_consts(input int fd, input int fn);
        for (int k = 0; k < NCH; k++) begin
            fdv[k] = fd;
            fnv[k] = fn;
        end
        set_consts();
    endtask

    task automatic send(input logic [NCH*A-1:0] vec, input bit byp);
        exp_t e;
        int   v;
        bit   s;
        i_in_valid = 1'b1;
        i_adc_in   = vec;
        i_bypass   = byp;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        if (cyc - last_acc >= NCH) begin
            last_acc = cyc;
            e.t0 = cyc;
            e.vals = '0;
            for (int k = 0; k < NCH; k++) begin
                if (byp) begin
                    v = int'(vec[k*A +: A]);
                    s = 1'b0;
                end else begin
                    ref_chan(int'(vec[k*A +: A]), prev[k], fdv[k], fnv[k], v, s);
                end
                e.vals[k*A +: A] = A'(v);
                if (s) m_sat[k] = 1'b1;
                prev[k] = int'(vec[k*A +: A]);
            end
            e.sat = m_sat;
            q.push_back(e);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 200) begin
            idle(1);
            b++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0 pending results", q.size());
            q.delete();
        end
        idle(2);
    endtask

    task automatic clear_flags();
        i_sat_clr = 1'b1;
        idle(1);
        i_sat_clr = 1'b0;
        m_sat = '0;
        m_ovr = 1'b0;
    endtask

    function automatic logic [NCH*A-1:0] splat(input int a);
        logic [NCH*A-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*A +: A] = A'(a);
        return r;
    endfunction

    function automatic logic [NCH*A-1:0] rand_vec();
        logic [NCH*A-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*A +: A] = A'($urandom_range(0, (1 << A) - 1));
        return r;
    endfunction

    // Monitor: pop expected set on each OUT_VALID and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < NCH; k++)
                        check($sformatf("out_ch%0d", k), longint'(o_adc_out[k*A +: A]),
                              longint'(e.vals[k*A +: A]));
                    check("sat_at_valid", longint'(o_sat), longint'(e.sat));
                    check("out_valid_latency", longint'(cyc), longint'(e.t0) + NCH + LATENCY);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NCH; k++) prev[k] = 0;
        all_consts(32, 16);
        idle(3);
        check("reset_adc_out", longint'(o_adc_out), 0);
        check("reset_out_valid", longint'(o_out_valid), 0);
        check("reset_sat", longint'(o_sat), 0);
        check("reset_overrun", longint'(o_overrun), 0);
        i_reset = 1'b0;
        idle(1);

        // 100 then 100 at exactly NCH spacing: expect 100, then 50
        send(splat(100), 1'b0);
        idle(NCH - 1);
        send(splat(100), 1'b0);
        drain();
        check("backtoback_no_overrun", longint'(o_overrun), longint'(m_ovr));

        // Negative difference clamps to zero
        send(splat(10), 1'b0);
        drain();
        check("neg_clamp_sat", longint'(o_sat), longint'(m_sat));

        // Saturation on channel 1 only, FN = 2.0
        all_consts(32, 32);
        send({A'(10), A'(0), A'(10)}, 1'b0);
        idle(NCH - 1);
        send({A'(10), A'(4000), A'(10)}, 1'b0);
        drain();
        check("sat_ch1_only", longint'(o_sat), longint'(m_sat));
        clear_flags();
        check("sat_cleared", longint'(o_sat), 0);

        // Round half up with FD = 0, FN = 1.5
        all_consts(0, 24);
        send({A'(1), A'(3), A'(3)}, 1'b0);
        idle(NCH - 1);
        send({A'(3), A'(1), A'(2)}, 1'b0);
        drain();

        // Strobe at spacing 2 is dropped and flags OVERRUN
        all_consts(32, 16);
        send(splat(200), 1'b0);
        idle(1);
        send(splat(900), 1'b0);
        drain();
        check("overrun_set", longint'(o_overrun), longint'(m_ovr));
        clear_flags();
        check("overrun_cleared", longint'(o_overrun), 0);

        // Bypass passes samples through
        send(rand_vec(), 1'b1);
        idle(NCH - 1);
        send(rand_vec(), 1'b0);
        drain();

        // Reset mid-sequence drops the in-flight set
        send(splat(1234), 1'b0);
        idle(2);
        i_reset = 1'b1;
        idle(1);
        check("midreset_adc_out", longint'(o_adc_out), 0);
        check("midreset_out_valid", longint'(o_out_valid), 0);
        check("midreset_sat", longint'(o_sat), 0);
        q.delete();
        for (int k = 0; k < NCH; k++) prev[k] = 0;
        m_sat = '0;
        m_ovr = 1'b0;
        last_acc = -1000;
        i_reset = 1'b0;
        idle(14);
        send(splat(100), 1'b0);
        drain();

        // Randomized batches with per-channel constants
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < NCH; k++) begin
                fdv[k] = $urandom_range(0, (1 << F) - 1);
                fnv[k] = $urandom_range(0, (1 << N) - 1);
            end
            set_consts();
            for (int i = 0; i < 8; i++) begin
                send(rand_vec(), $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) idle($urandom_range(0, NCH - 2));
                else                           idle(NCH - 1 + $urandom_range(0, 3));
            end
            drain();
            check("rand_overrun", longint'(o_overrun), longint'(m_ovr));
            check("rand_sat", longint'(o_sat), longint'(m_sat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deconvolve_multi.md
# deconvolve_multi

Parametrised, time-multiplexed FADC trace deconvolution for NCH channels sharing one multiply/subtract/normalise pipeline on the 120 MHz trigger clock. Each channel computes out[n] = round(FN·max(0, x[n] − FD·x[n−1])), saturated to full scale, with per-channel constants. It supersedes the single-channel 40 MHz deconvolver in the compatibility ToT-deconvolved trigger path: one instance serves all PMTs, adds reset, valid handshake, bypass and saturation/overrun flags.

## Interface
- NCH, 3, number of channels; 1..8
- ADC_WIDTH, 12, sample width, unsigned
- FD_BITS, 6, decay constant width, all fractional (.yyyyyy)
- FN_BITS, 6, normaliser width
- FN_FRAC_BITS, 4, fractional bits of normaliser (xx.yyyy)
- CLK  in  1  120 MHz clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  one-cycle strobe, new sample set on ADC_IN
- ADC_IN  in  NCH·ADC_WIDTH  filtered samples, channel k at bits [k·ADC_WIDTH +: ADC_WIDTH]
- FD  in  NCH·FD_BITS  per-channel decay constants, quasi-static
- FN  in  NCH·FN_BITS  per-channel normalisers, quasi-static
- BYPASS  in  1  1: output = input sample, same latency
- ADC_OUT  out  NCH·ADC_WIDTH  deconvolved samples, registered
- OUT_VALID  out  1  one-cycle strobe, full ADC_OUT vector updated
- SAT  out  NCH  sticky per-channel saturation flag
- OVERRUN  out  1  sticky, IN_VALID arrived while sequencing
- SAT_CLR  in  1  clears SAT and OVERRUN

## Operation
- On IN_VALID (idle): latch ADC_IN into hold register; channel counter steps 0..NCH−1, one channel per cycle into the pipeline.
- Per channel k: X = hold[k], P = prev[k]; prev[k] ← X on issue. prev is the previous accepted sample, not the previous output.
- B = {X, FD_BITS zeros} − P·FD[k], signed, ADC_WIDTH+FD_BITS+1 bits. B < 0 → C = 0, else C = B.
- D = C·FN[k], ADC_WIDTH+FD_BITS+FN_BITS bits; E = D + 2^(FD_BITS+FN_FRAC_BITS−1) (round half up).
- Result = E >> (FD_BITS+FN_FRAC_BITS); any bit above ADC_WIDTH−1 set → 2^ADC_WIDTH−1 and SAT[k] ← 1.
- BYPASS: result = X; no SAT update; prev still updated. BYPASS sampled with IN_VALID, applies to the whole sample set.
- IN_VALID while counter busy (< NCH cycles since accepted strobe): strobe ignored, OVERRUN ← 1, hold/prev untouched.
- SAT_CLR same cycle as new SAT event: set wins.
- FD/FN changes take effect for the next channel issued; no glitch protection required.
- Reset: ADC_OUT, prev, hold, pipeline, SAT, OVERRUN, OUT_VALID = 0; counter idle. Reset mid-sequence drops in-flight channels, no OUT_VALID.

## Timing
- Strobe accepted at edge t0 → channel k issued at t0+1+k.
- Pipeline: issue, product reg ×2, subtract, clamp, normalise product reg ×2, round, saturate/write = latency LAT = 8 from issue.
- ADC_OUT channel k updates at edge t0+1+k+LAT; OUT_VALID high for exactly the cycle after channel NCH−1 writes (t0+NCH+LAT+1 region: one cycle, all channels stable).
- Max strobe rate: one per NCH cycles (NCH=3 → 40 MHz nominal). Back-to-back at exactly NCH spacing accepted, no OVERRUN.
- Channels not yet rewritten hold previous set's values until their write edge.

## Structure
- Parameter defaults and ToT-deconv widths in sde_trigger_defs.vh (COMPATIBILITY_TOTD_* constants).
- Sub-module deconv_pipe: single-channel-wide datapath (multiply, subtract, clamp, normalise, round, saturate) with channel tag alongside; top holds counter, hold/prev register files, output demux, flags.
- Both multiplies registered twice to map onto DSP48 with MREG/PREG.

## Test plan
- FD=32, FN=16, all channels: sample sets 100 then 100 → outputs 100, then 50; OUT_VALID one pulse per set, 8+NCH cycles after strobe.
- prev=100, new=10, FD=32 → B negative → output 0, SAT stays 0.
- FN=32 (2.0), sample 4000 after 0 → output 4095, SAT[k]=1 only for that channel; SAT_CLR clears it.
- Rounding: FD=0, FN=24 (1.5), sample 3 → 4.5 rounds to 5; sample 1 → 1.5 → 2.
- IN_VALID at spacing 2 with NCH=3 → second strobe ignored, OVERRUN=1, outputs match first set only; BYPASS=1 → ADC_OUT equals ADC_IN after LAT.
- RESET asserted mid-sequence → all outputs 0 next edge, no OUT_VALID; next set after reset uses prev=0.
